calc_share_arbiter: RTL

- Shares one iterative calculator engine (ADD/SUB/MUL/DIV on 16-bit operands, 17-bit result, overflow flag) between NUM_CLIENTS requesters.
- Round-robin arbitration; latches the winner's operands, sequences the engine start/done handshake, and routes the result back to the winning client as a one-cycle response.
- Sits between client front-ends (keypad/UART sequencers) and the shared calculator datapath.

---
 rtl/calc_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/calc_share_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator arbiter: operand/result widths, op codes
// and the one-hot state encoding.
package calc_pkg;

  localparam int OPND_W = 16;
  localparam int RES_W  = 17;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_ISSUE = 4'b0010;
  localparam logic [ST_W-1:0] ST_WAIT  = 4'b0100;
  localparam logic [ST_W-1:0] ST_RESP  = 4'b1000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping from N-1 back to 0.
module rr_pick
  import calc_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_share_arbiter.sv
// Round-robin arbiter sharing one iterative calculator engine between clients.
// Optional WAIT-state timeout with engine abort: define CALC_ARB_TIMEOUT_EN.
module calc_share_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_CLIENTS    = 2,
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_CLIENTS-1:0]        Req,
  input  logic [OPND_W*NUM_CLIENTS-1:0] ReqA,
  input  logic [OPND_W*NUM_CLIENTS-1:0] ReqB,
  input  logic [2*NUM_CLIENTS-1:0]      ReqOp,
  output logic [NUM_CLIENTS-1:0]        Gnt,
  output logic [NUM_CLIENTS-1:0]        RspValid,
  output logic [RES_W-1:0]              RspC,
  output logic                          RspFlag,
  output logic                          RspErr,
  output logic                          Busy,
  output logic [OPND_W-1:0]             Eng_A,
  output logic [OPND_W-1:0]             Eng_B,
  output logic [1:0]                    Eng_Op,
  output logic                          Eng_Start,
  output logic                          Eng_Abort,
  input  logic                          Eng_Done,
  input  logic [RES_W-1:0]              Eng_C,
  input  logic                          Eng_Flag,
  output logic                          QIdle,
  output logic                          QIssue,
  output logic                          QWait,
  output logic                          QResp
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  logic [ST_W-1:0]        state, state_nxt;
  logic [IDX_W-1:0]       ptr, idx;
  logic [NUM_CLIENTS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [OPND_W-1:0]      pick_a, pick_b;
  logic [1:0]             pick_op;
  logic                   div_zero;
  logic                   tmo_hit;

  rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (Req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_a  = '0;
    pick_b  = '0;
    pick_op = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_grant[i]) begin
        pick_a  = ReqA[OPND_W*i +: OPND_W];
        pick_b  = ReqB[OPND_W*i +: OPND_W];
        pick_op = ReqOp[2*i +: 2];
      end
    end
  end

  // A divide by zero is answered directly without ever starting the engine.
  assign div_zero = (pick_op == OP_DIV) && (pick_b == '0);

`ifdef CALC_ARB_TIMEOUT_EN
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] tmo_cnt;

  assign tmo_hit = (state == ST_WAIT) && !Eng_Done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tmo_cnt   <= '0;
      Eng_Abort <= 1'b0;
    end else begin
      Eng_Abort <= tmo_hit;
      if (state == ST_ISSUE) tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 17'd1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign Eng_Abort = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = div_zero ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (Eng_Done || tmo_hit) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Eng_Start = (state == ST_ISSUE);
    Busy      = (state != ST_IDLE);
    QIdle     = (state == ST_IDLE);
    QIssue    = (state == ST_ISSUE);
    QWait     = (state == ST_WAIT);
    QResp     = (state == ST_RESP);
  end

  // RspValid is registered out of RESP, so a divide-by-zero grant and its
  // response land in consecutive cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr      <= IDX_W'(NUM_CLIENTS - 1);
      idx      <= '0;
      Gnt      <= '0;
      RspValid <= '0;
      RspC     <= '0;
      RspFlag  <= 1'b0;
      RspErr   <= 1'b0;
      Eng_A    <= '0;
      Eng_B    <= '0;
      Eng_Op   <= '0;
    end else begin
      Gnt      <= '0;
      RspValid <= (state == ST_RESP) ? (NUM_CLIENTS'(1) << idx) : '0;
      if ((state == ST_IDLE) && pick_any) begin
        Gnt    <= pick_grant;
        ptr    <= pick_idx;
        idx    <= pick_idx;
        Eng_A  <= pick_a;
        Eng_B  <= pick_b;
        Eng_Op <= pick_op;
        if (div_zero) begin
          RspC    <= '0;
          RspFlag <= 1'b0;
          RspErr  <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        if (Eng_Done) begin
          RspC    <= Eng_C;
          RspFlag <= Eng_Flag;
          RspErr  <= 1'b0;
        end else if (tmo_hit) begin
          RspC    <= '0;
          RspFlag <= 1'b0;
          RspErr  <= 1'b1;
        end
      end
    end
  end

endmodule
